alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
Downstream stage of the 16-bit combinational ALU (ops add/sub/and/xor/xnor/inc/dec/not, sel 0-7; carry_out meaningful only for add). Captures each ALU result with its sel code and carry_out, derives status flags, and queues them in a small FIFO. The FIFO drains to the consumer (writeback/bus) over a valid/ready handshake. Also keeps a saturating count of add-carry events for debug/status.

Parameters:
WIDTH, 16, data width of ALU result
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 8, width of carry-event counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of FIFO contents (not the counter)
in_valid  input  1  ALU result valid this cycle
in_ready  output  1  buffer can accept an entry
alu_result  input  WIDTH  ALU result
alu_carry  input  1  ALU carry_out
alu_sel  input  4  op code that produced the result
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_result  output  WIDTH  head result
out_sel  output  4  head op code
out_flags  output  4  head flags {I,C,N,Z}
level  output  $clog2(DEPTH)+1  entries held
carry_events  output  CNT_W  saturating count of accepted entries with C=1

Behaviour:
- Reset (rst_n low, async): FIFO empty, pointers 0, level=0, carry_events=0, in_ready=1 once out of reset, out_valid=0, out_result/out_sel/out_flags=0.
- Flag derivation at push, from inputs in the same cycle:
  - Z = (alu_result == 0)
  - N = alu_result[WIDTH-1]
  - C = alu_carry AND (alu_sel == 4'b0000); carry on any other sel is ignored
  - I = (alu_sel >= 4'b1000), i.e. undefined op; the result is stored as given
- Push: in_valid && in_ready at rising edge -> entry written at wr_ptr, wr_ptr increments modulo DEPTH.
- Pop: out_valid && out_ready at rising edge -> rd_ptr increments modulo DEPTH.
- in_ready = (level != DEPTH). Registered/derived from state only; no combinational path from out_ready. When full, no push occurs even if a pop happens in the same cycle.
- out_valid = (level != 0). out_result/out_sel/out_flags show the head entry when out_valid=1 and are forced to 0 when empty. An entry becomes visible the cycle after its push (latency 1). No bypass.
- Simultaneous push and pop with 0 < level < DEPTH: both happen, level unchanged, order preserved.
- Pointer wrap: pointers carry an extra MSB, or level is tracked explicitly. Full/empty stay correct across any number of wraps.
- carry_events increments by 1 on each accepted push with C=1 and saturates at 2^CNT_W-1. It is cleared only by reset.
- flush (sync, highest priority over push/pop that cycle): pointers and level go to 0, and out_valid drops next cycle. A push presented in the flush cycle is dropped, and it does not increment carry_events.
- in_valid while in_ready=0: the entry is not captured. The upstream holds it; the buffer never drops data silently except on flush.
- Reset asserted mid-transfer: state clears immediately (async). No entry survives. The first push after deassertion is accepted normally.

Test Plan:
- Push result=16'h0015, sel=0000, carry=0 -> next cycle out_valid=1, out_result=0015, out_flags=4'b0000, level=1. Pop -> out_valid=0, outputs 0.
- Push result=16'h0000, sel=0000, carry=1 (FFFF+0001) -> out_flags=4'b0101 (C,Z), carry_events=1. Push result=16'h8000, sel=0110, carry=1 -> flags=4'b0010, carry_events stays 1.
- out_ready=0, push 5 consecutive entries 1..5 -> in_ready=0 after 4th, level=4, 5th not captured. Drain -> 1,2,3,4 in order.
- Hold level=2, assert in_valid and out_ready together for 10 cycles (forces wraps) -> level stays 2, output sequence matches input order exactly.
- Push result=16'h0000, sel=1001 -> out_flags=4'b1001. Force 300 add-carry pushes with continuous draining -> carry_events=255.
- Fill to 3, assert flush together with in_valid -> next cycle level=0, out_valid=0, carry_events unchanged. Also, with level=3, drop rst_n asynchronously between edges -> level=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU, the result buffer and the downstream consumer.
// master: the side that produces ALU results and consumes buffered entries.
// slave: the buffer itself.
interface alu_result_buffer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic [3:0]       alu_sel;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_sel;
    logic [3:0]       out_flags;

    modport master (
        output in_valid, alu_result, alu_carry, alu_sel, out_ready,
        input  in_ready, out_valid, out_result, out_sel, out_flags
    );

    modport slave (
        input  in_valid, alu_result, alu_carry, alu_sel, out_ready,
        output in_ready, out_valid, out_result, out_sel, out_flags
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Result buffer behind the 16-bit ALU: captures result, op code and derived
// flags {I,C,N,Z} into a small FIFO drained over valid/ready, and keeps a
// saturating count of accepted add-with-carry entries.
module alu_result_buffer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    alu_result_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         carry_events
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = 4 + 4 + WIDTH;

    // Flags {I,C,N,Z}: carry only counts for add (sel 0); sel >= 8 is undefined.
    function automatic logic [3:0] derive_flags(input logic [WIDTH-1:0] res,
                                                input logic             carry,
                                                input logic [3:0]       sel);
        logic f_i, f_c, f_n, f_z;
        f_i = (sel >= 4'b1000);
        f_c = carry && (sel == 4'b0000);
        f_n = res[WIDTH-1];
        f_z = (res == '0);
        return {f_i, f_c, f_n, f_z};
    endfunction

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cevt_q, cevt_d;
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] entry_d;
    logic [3:0]       flags_in;
    logic             push, pop;
    logic             not_full, not_empty;
    logic [ENT_W-1:0] head;

    // Handshake qualification and next-state for pointers, level and counter.
    always_comb begin
        not_full  = (level_q != LVL_W'(DEPTH));
        not_empty = (level_q != '0);
        flags_in  = derive_flags(bus.alu_result, bus.alu_carry, bus.alu_sel);
        entry_d   = {bus.alu_sel, flags_in, bus.alu_result};
        // Flush overrides both sides: the pushed entry is dropped and uncounted.
        push      = bus.in_valid && not_full && !flush;
        pop       = not_empty && bus.out_ready && !flush;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        cevt_d    = cevt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end

        if (push && flags_in[2] && (cevt_q != {CNT_W{1'b1}}))
            cevt_d = cevt_q + CNT_W'(1);
    end

    // Control state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cevt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cevt_q   <= cevt_d;
        end
    end

    // Entry storage; contents are never read while empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry_d;
    end

    // Head presentation, zeroed whenever the buffer is empty.
    always_comb begin
        head           = not_empty ? mem_q[rd_ptr_q] : '0;
        bus.in_ready   = not_full;
        bus.out_valid  = not_empty;
        bus.out_sel    = head[ENT_W-1 -: 4];
        bus.out_flags  = head[WIDTH +: 4];
        bus.out_result = head[WIDTH-1:0];
        level          = level_q;
        carry_events   = cevt_q;
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Randomized bench for alu_result_buffer against a queue-based reference model.
module tb_alu_result_buffer;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [3:0]       sel;
        logic [3:0]       flags;
        logic [WIDTH-1:0] res;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       carry_events;

    alu_result_buffer_if #(.WIDTH(WIDTH)) bus ();

    alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus.slave),
        .level        (level),
        .carry_events (carry_events)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    ent_t q[$];
    int   m_cnt    = 0;
    ent_t popped[$];
    ent_t pushed[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic ent_t mk_entry(input logic [WIDTH-1:0] r, input logic c, input logic [3:0] s);
        ent_t e;
        e.res   = r;
        e.sel   = s;
        e.flags = {(s > 7) ? 1'b1 : 1'b0, (c && s == 0) ? 1'b1 : 1'b0,
                   (r >= 16'h8000) ? 1'b1 : 1'b0, (r == 0) ? 1'b1 : 1'b0};
        return e;
    endfunction

    task automatic check_outputs();
        ent_t h;
        h = (q.size() > 0) ? q[0] : '0;
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("in_ready",  32'(bus.in_ready),  32'(q.size() < DEPTH));
        chk("level",     32'(level),         32'(q.size()));
        chk("out_result",32'(bus.out_result),32'(h.res));
        chk("out_sel",   32'(bus.out_sel),   32'(h.sel));
        chk("out_flags", 32'(bus.out_flags), 32'(h.flags));
        chk("carry_evt", 32'(carry_events),  32'(m_cnt));
    endtask

    // One clock: model sees the inputs driven before the edge, then compares.
    task automatic step();
        bit   acc, dq;
        ent_t e;
        @(posedge clk);
        e   = mk_entry(bus.alu_result, bus.alu_carry, bus.alu_sel);
        acc = bus.in_valid && (q.size() < DEPTH) && !flush;
        dq  = (q.size() > 0) && bus.out_ready && !flush;
        if (flush) q.delete();
        else begin
            if (dq) popped.push_back(q.pop_front());
            if (acc) begin
                q.push_back(e);
                pushed.push_back(e);
                if (e.flags[2] && m_cnt < CMAX) m_cnt++;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] r, input logic [3:0] s,
                         input bit c, input bit ordy, input bit fl);
        bus.in_valid   = v;
        bus.alu_result = r;
        bus.alu_sel    = s;
        bus.alu_carry  = c;
        bus.out_ready  = ordy;
        flush          = fl;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_result",32'(bus.out_result), 0);
        chk("rst_cevt",  32'(carry_events), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // Single entry, then pop.
        drive(1, 16'h0015, 4'b0000, 0, 0, 0); step();
        chk("t1_result", 32'(bus.out_result), 32'h0015);
        chk("t1_flags",  32'(bus.out_flags), 32'b0000);
        drive(0, 0, 0, 0, 1, 0); step();
        chk("t1_empty", 32'(bus.out_valid), 0);

        // Add carry counts; carry on other ops is ignored.
        drive(1, 16'h0000, 4'b0000, 1, 0, 0); step();
        chk("t2_flags", 32'(bus.out_flags), 32'b0101);
        chk("t2_cevt",  32'(carry_events), 1);
        drive(1, 16'h8000, 4'b0110, 1, 1, 0); step();
        drive(0, 0, 0, 0, 0, 0); step();
        chk("t2b_flags", 32'(bus.out_flags), 32'b0010);
        chk("t2b_cevt",  32'(carry_events), 1);
        drive(0, 0, 0, 0, 1, 0); step();

        // Fill past full, then drain in order.
        for (int i = 1; i <= 5; i++) begin
            drive(1, WIDTH'(i), 4'b0010, 0, 0, 0); step();
        end
        chk("t3_full_lvl", 32'(level), 4);
        chk("t3_full_rdy", 32'(bus.in_ready), 0);
        for (int i = 1; i <= 4; i++) begin
            chk("t3_order", 32'(bus.out_result), 32'(i));
            drive(0, 0, 0, 0, 1, 0); step();
        end

        // Steady level 2 with simultaneous push and pop across pointer wraps.
        for (int i = 0; i < 2; i++) begin
            drive(1, WIDTH'(16'h100 + i), 4'b0011, 0, 0, 0); step();
        end
        popped.delete();
        pushed.delete();
        for (int i = 2; i < 12; i++) begin
            drive(1, WIDTH'(16'h100 + i), 4'b0011, 0, 1, 0); step();
            chk("t4_level", 32'(level), 2);
        end
        for (int i = 0; i < 10; i++)
            chk("t4_seq", 32'(popped[i].res), 32'(16'h100 + i));
        drive(0, 0, 0, 0, 1, 0); step(); step();

        // Undefined op flag.
        drive(1, 16'h0000, 4'b1001, 0, 0, 0); step();
        chk("t5_flags", 32'(bus.out_flags), 32'b1001);
        drive(0, 0, 0, 0, 1, 0); step();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 16'h0 : WIDTH'($urandom),
                  $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15)),
                  $urandom_range(0, 1) != 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 31) == 0);
            step();
        end
        drive(0, 0, 0, 0, 1, 0); step(); step(); step(); step();

        // Saturating carry counter.
        for (int i = 0; i < 300; i++) begin
            drive(1, WIDTH'($urandom), 4'b0000, 1, 1, 0); step();
        end
        chk("t5_sat", 32'(carry_events), CMAX);
        drive(0, 0, 0, 0, 1, 0); step(); step();

        // Flush with a concurrent push.
        for (int i = 0; i < 3; i++) begin
            drive(1, WIDTH'(16'h200 + i), 4'b0001, 0, 0, 0); step();
        end
        chk("t6_pre", 32'(level), 3);
        m_cnt = CMAX;
        drive(1, 16'h0, 4'b0000, 1, 0, 1); step();
        chk("t6_lvl", 32'(level), 0);
        chk("t6_vld", 32'(bus.out_valid), 0);
        chk("t6_cevt", 32'(carry_events), CMAX);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) begin
            drive(1, WIDTH'(16'h300 + i), 4'b0000, 1, 0, 0); step();
        end
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_lvl", 32'(level), 0);
        chk("t7_vld", 32'(bus.out_valid), 0);
        chk("t7_cevt", 32'(carry_events), 0);
        q.delete();
        m_cnt = 0;
        #3 rst_n = 1'b1;
        drive(1, 16'h0042, 4'b0000, 0, 0, 0); step();
        chk("t7_after", 32'(bus.out_result), 32'h0042);
        drive(0, 0, 0, 0, 1, 0); step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
